stream_demux: RTL and testbench

//  Registered 1-to-N demultiplexer with valid/ready handshake; the inverse of the combinational mux.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/stream_slot.sv | 78 +++++++
 rtl/stream_demux.sv | 71 +++++++
 tb/tb_stream_demux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for stream_demux. STREAM_DEMUX_SKID_EN selects 2-entry channel buffers
// (BUF_DEPTH=2) instead of the default single-entry buffers.
package demux_pkg;

  function automatic int sel_bits(input int n);
    return $clog2(n);
  endfunction

`ifdef STREAM_DEMUX_SKID_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    CH_EMPTY = 2'd0,
    CH_ONE   = 2'd1,
    CH_TWO   = 2'd2
  } chan_state_t;

endpackage

// File: rtl/stream_slot.sv
// Per-channel output buffer for stream_demux: holds up to BUF_DEPTH words and presents
// the oldest one with a valid/ready handshake.
module stream_slot
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  full
);

  chan_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] head, head_next;
  logic [DATA_WIDTH-1:0] tail, tail_next;
  logic                  pop;

  assign valid = (state != CH_EMPTY);
  assign pop   = valid && ready;
  assign data  = head;
  assign full  = (BUF_DEPTH == 1) ? valid : (state == CH_TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  // head is always the word on the output; tail only fills while head is stalled
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    case (state)
      CH_EMPTY: begin
        if (push) begin
          state_next = CH_ONE;
          head_next  = push_data;
        end
      end
      CH_ONE: begin
        if (push && pop) begin
          head_next = push_data;
        end else if (push) begin
          if (BUF_DEPTH > 1) begin
            state_next = CH_TWO;
            tail_next  = push_data;
          end
        end else if (pop) begin
          state_next = CH_EMPTY;
        end
      end
      CH_TWO: begin
        if (pop) begin
          head_next = tail;
          if (push) begin
            tail_next = push_data;
          end else begin
            state_next = CH_ONE;
          end
        end
      end
      default: state_next = CH_EMPTY;
    endcase
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel buffering.
// Define STREAM_DEMUX_SKID_EN for 2-entry buffers and an o_ready free of i_ready paths.
module stream_demux
  import demux_pkg::*;
#(
  parameter  int NUM_OUTPUTS = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int SELECT_BITS = sel_bits(NUM_OUTPUTS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic [SELECT_BITS-1:0]            i_select,
  output logic [NUM_OUTPUTS-1:0]            o_valid,
  input  logic [NUM_OUTPUTS-1:0]            i_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_data_bus,
  output logic                              o_sel_err
);

  logic [NUM_OUTPUTS-1:0] push;
  logic [NUM_OUTPUTS-1:0] full;
  logic                   sel_ok;
  logic                   accept;

  // Out-of-range selects fall through with o_ready=1 so the word is consumed and dropped
  always_comb begin
    o_ready = 1'b1;
    sel_ok  = 1'b0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (int'(i_select) == k) begin
        sel_ok = 1'b1;
`ifdef STREAM_DEMUX_SKID_EN
        o_ready = !full[k];
`else
        o_ready = !full[k] || i_ready[k];
`endif
      end
    end
    accept = i_valid && o_ready;
    push   = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      push[k] = accept && (int'(i_select) == k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sel_err <= 1'b0;
    end else begin
      o_sel_err <= accept && !sel_ok;
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
    stream_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (i_clk),
      .rst      (i_rst),
      .push     (push[k]),
      .push_data(i_data),
      .valid    (o_valid[k]),
      .ready    (i_ready[k]),
      .data     (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .full     (full[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard testbench for stream_demux: directed words are queued per channel on acceptance
// and a negedge monitor checks every delivered word and hold stability.
module tb_stream_demux;

  localparam int NO = 4;
  localparam int DW = 32;
`ifdef STREAM_DEMUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [DW-1:0]    i_data;
  logic [1:0]       i_select;
  logic [NO-1:0]    o_valid;
  logic [NO-1:0]    i_ready;
  logic [NO*DW-1:0] o_data_bus;
  logic             o_sel_err;

  logic             v3;
  logic             r3;
  logic [DW-1:0]    d3;
  logic [1:0]       s3;
  logic [2:0]       ov3;
  logic [2:0]       ir3;
  logic [3*DW-1:0]  bus3;
  logic             err3;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] expq[NO][$];
  bit            prev_hold[NO];
  logic [DW-1:0] prev_data[NO];

  always #5 clk = ~clk;

  stream_demux #(.NUM_OUTPUTS(NO), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_select(i_select), .o_valid(o_valid), .i_ready(i_ready), .o_data_bus(o_data_bus),
    .o_sel_err(o_sel_err)
  );

  stream_demux #(.NUM_OUTPUTS(3), .DATA_WIDTH(DW)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(v3), .o_ready(r3), .i_data(d3),
    .i_select(s3), .o_valid(ov3), .i_ready(ir3), .o_data_bus(bus3),
    .o_sel_err(err3)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers one word for one cycle; queues it as expected output only if it was accepted
  task automatic applyStimulus(input int sel, input logic [DW-1:0] d, input bit chk,
                               input bit exp_ready, output bit acc);
    i_valid  = 1'b1;
    i_select = sel[1:0];
    i_data   = d;
    @(negedge clk);
    acc = o_ready;
    if (chk) checkOutput("o_ready", {127'b0, o_ready}, {127'b0, exp_ready});
    @(posedge clk);
    if (acc) expq[sel].push_back(d);
    #1 i_valid = 1'b0;
  endtask

  task automatic sendWord(input int sel, input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) applyStimulus(sel, d, 1'b0, 1'b0, acc);
    if (!acc) checkOutput("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every channel transfer, and enforce hold stability under stall
  always @(negedge clk) begin
    for (int k = 0; k < NO; k++) begin
      if (rst) begin
        prev_hold[k] = 1'b0;
      end else begin
        if (prev_hold[k]) begin
          checkOutput($sformatf("hold_valid_ch%0d", k), {127'b0, o_valid[k]}, 128'd1);
          checkOutput($sformatf("hold_data_ch%0d", k), o_data_bus[k*DW +: DW], prev_data[k]);
        end
        if (o_valid[k] && i_ready[k]) begin
          if (expq[k].size() == 0) begin
            checkOutput($sformatf("unexpected_ch%0d", k), o_data_bus[k*DW +: DW], 128'hx);
          end else begin
            checkOutput($sformatf("data_ch%0d", k), o_data_bus[k*DW +: DW], expq[k].pop_front());
          end
        end
        prev_hold[k] = o_valid[k] && !i_ready[k];
        prev_data[k] = o_data_bus[k*DW +: DW];
      end
    end
  end

  initial begin
    bit acc;
    rst = 1'b1; i_valid = 1'b1; i_select = 2'd1; i_data = 32'h1234; i_ready = '0;
    v3 = 1'b0; s3 = 2'd0; d3 = '0; ir3 = 3'b111;

    $display("[TB] reset");
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_o_valid", o_valid, 0);
      checkOutput("rst_o_data_bus", o_data_bus, 0);
      checkOutput("rst_o_sel_err", {127'b0, o_sel_err}, 0);
      checkOutput("rst_err3", {127'b0, err3}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;

    $display("[TB] routing");
    i_ready = 4'hF;
    for (int k = 0; k < NO; k++) begin
      applyStimulus(k, 32'hA0 + k, 1'b1, 1'b1, acc);
      @(negedge clk);
      checkOutput("route_o_valid", o_valid, 128'd1 << k);
      checkOutput("route_sel_err", {127'b0, o_sel_err}, 0);
      @(posedge clk); #1;
    end
    idle(2);

    $display("[TB] backpressure");
    i_ready = 4'b1011;
    applyStimulus(2, 32'h11, 1'b1, 1'b1, acc);
    applyStimulus(2, 32'h22, 1'b1, SKID, acc);
    applyStimulus(2, 32'h33, 1'b1, 1'b0, acc);
    @(negedge clk);
    checkOutput("bp_ch2_data", o_data_bus[2*DW +: DW], 32'h11);
    checkOutput("bp_o_valid", o_valid, 4'b0100);
    @(posedge clk); #1;
    i_ready = 4'hF;
    if (!SKID) sendWord(2, 32'h22);
    sendWord(2, 32'h33);
    idle(4);

    $display("[TB] independence");
    i_ready = 4'b1101;
    for (int n = 0; n < (SKID ? 2 : 1); n++) applyStimulus(1, 32'h55 + n, 1'b1, 1'b1, acc);
    applyStimulus(1, 32'h57, 1'b1, 1'b0, acc);
    for (int n = 0; n < 8; n++) applyStimulus(0, 32'hB0 + n, 1'b1, 1'b1, acc);
    @(negedge clk);
    checkOutput("ind_ch1_stalled", {127'b0, o_valid[1]}, 1);
    @(posedge clk); #1;
    i_ready = 4'hF;
    sendWord(1, 32'h57);
    idle(4);

    $display("[TB] out-of-range select");
    v3 = 1'b1; s3 = 2'd3; d3 = 32'hDEAD;
    @(negedge clk);
    checkOutput("oor_ready", {127'b0, r3}, 1);
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    checkOutput("oor_err_pulse", {127'b0, err3}, 1);
    checkOutput("oor_no_valid", {125'b0, ov3}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("oor_err_clear", {127'b0, err3}, 0);
    checkOutput("oor_no_valid2", {125'b0, ov3}, 0);
    @(posedge clk); #1;
    v3 = 1'b1; s3 = 2'd2; d3 = 32'hBEEF;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    checkOutput("inrange_no_err", {127'b0, err3}, 0);
    checkOutput("inrange_valid", {125'b0, ov3}, 3'b100);
    checkOutput("inrange_data", bus3[2*DW +: DW], 32'hBEEF);
    @(posedge clk); #1;

    $display("[TB] reset mid-flight");
    i_ready = 4'b0000;
    applyStimulus(0, 32'hC0, 1'b1, 1'b1, acc);
    applyStimulus(3, 32'hC3, 1'b1, 1'b1, acc);
    @(negedge clk);
    checkOutput("mid_o_valid", o_valid, 4'b1001);
    @(posedge clk); #1;
    rst = 1'b1;
    expq[0].delete();
    expq[3].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_flushed_valid", o_valid, 0);
    checkOutput("mid_flushed_bus", o_data_bus, 0);
    @(posedge clk); #1;
    i_ready = 4'hF;
    idle(3);
    @(negedge clk);
    checkOutput("mid_never_delivered", o_valid, 0);
    @(posedge clk); #1;

    idle(4);
    for (int k = 0; k < NO; k++) checkOutput($sformatf("drain_ch%0d", k), expq[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
